// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port memory between the instruction-fetch port and the
// load/store port. One transaction is in flight at a time. The response is
// routed back to the port that issued it. Fetch is protected from starvation
// by a bounded run of LSU wins, and a stuck memory is cut off by a response
// timeout that returns an error to the owner.
module mem_arbiter #(
    parameter int STARVE_LIMIT   = 4,   // LSU wins in a row, while fetch waits, before fetch is forced through
    parameter int TIMEOUT_CYCLES = 16   // WAIT cycles without a memory response before aborting with error
) (
    input  logic        clock,
    input  logic        reset,

    // instruction-fetch port (read only)
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    output logic        if_err_o,

    // load/store port
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [3:0]  lsu_be_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_gnt_o,
    output logic        lsu_rvalid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_err_o,

    // memory side
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int STARVE_W  = $clog2(STARVE_LIMIT + 1);
    localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [STARVE_W-1:0]  STARVE_MAX   = STARVE_W'(STARVE_LIMIT);
    // The counter is compared before it is bumped, so the last WAIT cycle is
    // the one where it still holds TIMEOUT_CYCLES-1.
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_LSU
    } owner_t;

    state_t                state;
    owner_t                owner;
    logic [STARVE_W-1:0]   starve_cnt;
    logic [TIMEOUT_W-1:0]  timeout_cnt;

    logic                  grant_if;
    logic                  grant_lsu;
    logic                  fetch_starved;
    logic                  resp_done;
    logic                  resp_err;
    logic [31:0]           resp_data;

    // Arbitration: grants only in IDLE; LSU has priority unless fetch has
    // waited through STARVE_LIMIT consecutive LSU wins.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        grant_if      = 1'b0;
        grant_lsu     = 1'b0;
        fetch_starved = (starve_cnt == STARVE_MAX);
        if (state == ST_IDLE) begin
            if (lsu_req_i && !(if_req_i && fetch_starved)) begin
                grant_lsu = 1'b1;
            end else if (if_req_i) begin
                grant_if = 1'b1;
            end
        end
    end

    assign if_gnt_o  = grant_if;
    assign lsu_gnt_o = grant_lsu;

    // Response selection in WAIT: a memory answer wins over an expiring
    // timeout; stores return zero data, timeouts return zero data with error.
    always_comb begin
        resp_done = mem_rvalid_i || (timeout_cnt == TIMEOUT_LAST);
        resp_err  = !mem_rvalid_i;
        resp_data = (mem_rvalid_i && !mem_we_o) ? mem_rdata_i : 32'h0;
    end

    // Transaction FSM with registered outputs: latch the winner's payload,
    // pulse the memory request, wait for the answer or the timeout, and
    // deliver a one-cycle response to the owner only.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state        <= ST_IDLE;
            owner        <= OWN_IF;
            starve_cnt   <= '0;
            timeout_cnt  <= '0;
            if_rvalid_o  <= 1'b0;
            if_rdata_o   <= 32'h0;
            if_err_o     <= 1'b0;
            lsu_rvalid_o <= 1'b0;
            lsu_rdata_o  <= 32'h0;
            lsu_err_o    <= 1'b0;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_be_o     <= 4'h0;
            mem_addr_o   <= 32'h0;
            mem_wdata_o  <= 32'h0;
        end else begin
            // The memory strobe is a single-cycle pulse unless re-armed below.
            mem_req_o <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (grant_lsu) begin
                        owner       <= OWN_LSU;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= lsu_we_i;
                        mem_be_o    <= lsu_be_i;
                        mem_addr_o  <= lsu_addr_i;
                        mem_wdata_o <= lsu_wdata_i;
                        state       <= ST_ISSUE;
                        // Only a win over a waiting fetch counts toward starvation.
                        if (if_req_i && !fetch_starved) begin
                            starve_cnt <= starve_cnt + STARVE_W'(1);
                        end
                    end else if (grant_if) begin
                        owner       <= OWN_IF;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_be_o    <= 4'hF;
                        mem_addr_o  <= if_addr_i;
                        mem_wdata_o <= 32'h0;
                        starve_cnt  <= '0;
                        state       <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    timeout_cnt <= '0;
                    state       <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (resp_done) begin
                        state <= ST_RESP;
                        if (owner == OWN_LSU) begin
                            lsu_rvalid_o <= 1'b1;
                            lsu_rdata_o  <= resp_data;
                            lsu_err_o    <= resp_err;
                        end else begin
                            if_rvalid_o  <= 1'b1;
                            if_rdata_o   <= resp_data;
                            if_err_o     <= resp_err;
                        end
                    end else begin
                        timeout_cnt <= timeout_cnt + TIMEOUT_W'(1);
                    end
                end

                ST_RESP: begin
                    if_rvalid_o  <= 1'b0;
                    if_rdata_o   <= 32'h0;
                    if_err_o     <= 1'b0;
                    lsu_rvalid_o <= 1'b0;
                    lsu_rdata_o  <= 32'h0;
                    lsu_err_o    <= 1'b0;
                    state        <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter. A transaction-level model predicts, from
// grant cycles and memory answer cycles, when each output must fire; one
// compare process checks the DUT against it every cycle, and each scenario
// pins the model with hand-computed latencies and values.
module tb_mem_arbiter;

    localparam int STARVE_LIMIT   = 4;
    localparam int TIMEOUT_CYCLES = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        if_err_o;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [3:0]  lsu_be_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_gnt_o;
    logic        lsu_rvalid_o;
    logic [31:0] lsu_rdata_o;
    logic        lsu_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    always #5 clock = ~clock;

    mem_arbiter #(
        .STARVE_LIMIT   (STARVE_LIMIT),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_gnt_o     (if_gnt_o),
        .if_rvalid_o  (if_rvalid_o),
        .if_rdata_o   (if_rdata_o),
        .if_err_o     (if_err_o),
        .lsu_req_i    (lsu_req_i),
        .lsu_we_i     (lsu_we_i),
        .lsu_be_i     (lsu_be_i),
        .lsu_addr_i   (lsu_addr_i),
        .lsu_wdata_i  (lsu_wdata_i),
        .lsu_gnt_o    (lsu_gnt_o),
        .lsu_rvalid_o (lsu_rvalid_o),
        .lsu_rdata_o  (lsu_rdata_o),
        .lsu_err_o    (lsu_err_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s cycle=%0d got=0x%08h expected=0x%08h", name, cyc, actual, expected);
        end
    endtask

    // ------------------------------------------------------------------
    // Memory responder: answers mem_delay cycles after the request
    // (0 = never), plus an optional stray pulse at inject_at.
    // ------------------------------------------------------------------
    int          mem_delay = 1;
    logic [31:0] mem_data  = 32'hDEADBEEF;
    int          resp_at   = -1;
    int          inject_at = -1;

    always @(negedge clock) begin
        if (mem_req_o === 1'b1 && mem_delay > 0) resp_at = cyc + mem_delay;
    end

    initial begin
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        forever begin
            @(posedge clock);
            #1;
            mem_rvalid_i = (cyc == resp_at) || (cyc == inject_at);
            mem_rdata_i  = mem_data;
        end
    end

    // ------------------------------------------------------------------
    // Transaction-level model plus event log, checked once per cycle.
    // ------------------------------------------------------------------
    bit          armed   = 1'b0;
    bit          busy    = 1'b0;
    bit          own_lsu;
    int          g_cyc;
    int          r_cyc;
    int          starve  = 0;
    bit          m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    bit          m_err;

    byte         grant_log[$];
    int          if_rv_count  = 0;
    int          lsu_rv_count = 0;
    int          last_if_gnt_cyc, last_lsu_gnt_cyc, last_req_cyc;
    int          last_if_rv_cyc, last_lsu_rv_cyc;
    logic [31:0] last_req_addr, last_if_rdata, last_lsu_rdata;
    logic [3:0]  last_req_be;
    logic        last_req_we, last_if_err, last_lsu_err;
    logic [31:0] last_st_addr, last_st_wdata;
    logic [3:0]  last_st_be;

    always @(negedge clock) begin
        bit e_if_gnt;
        bit e_lsu_gnt;
        bit e_req;
        bit e_rv;

        if (if_gnt_o === 1'b1)  begin grant_log.push_back("I"); last_if_gnt_cyc  = cyc; end
        if (lsu_gnt_o === 1'b1) begin grant_log.push_back("L"); last_lsu_gnt_cyc = cyc; end
        if (mem_req_o === 1'b1) begin
            last_req_cyc  = cyc;
            last_req_addr = mem_addr_o;
            last_req_be   = mem_be_o;
            last_req_we   = mem_we_o;
            if (mem_we_o === 1'b1) begin
                last_st_addr  = mem_addr_o;
                last_st_be    = mem_be_o;
                last_st_wdata = mem_wdata_o;
            end
        end
        if (if_rvalid_o === 1'b1) begin
            if_rv_count++; last_if_rv_cyc = cyc; last_if_rdata = if_rdata_o; last_if_err = if_err_o;
        end
        if (lsu_rvalid_o === 1'b1) begin
            lsu_rv_count++; last_lsu_rv_cyc = cyc; last_lsu_rdata = lsu_rdata_o; last_lsu_err = lsu_err_o;
        end

        e_if_gnt  = 1'b0;
        e_lsu_gnt = 1'b0;
        if (armed) begin
            if (!busy) begin
                if (lsu_req_i && !(if_req_i && starve == STARVE_LIMIT)) e_lsu_gnt = 1'b1;
                else if (if_req_i)                                      e_if_gnt  = 1'b1;
            end
            e_req = busy && (cyc == g_cyc + 1);
            e_rv  = busy && (cyc == r_cyc);

            check("if_gnt",     if_gnt_o,     e_if_gnt);
            check("lsu_gnt",    lsu_gnt_o,    e_lsu_gnt);
            check("mem_req",    mem_req_o,    e_req);
            check("if_rvalid",  if_rvalid_o,  e_rv && !own_lsu);
            check("lsu_rvalid", lsu_rvalid_o, e_rv && own_lsu);
            if (e_req) begin
                check("mem_addr", mem_addr_o, m_addr);
                check("mem_we",   mem_we_o,   m_we);
                check("mem_be",   mem_be_o,   m_be);
                if (m_we) check("mem_wdata", mem_wdata_o, m_wdata);
            end
            if (e_rv && own_lsu) begin
                check("lsu_rdata", lsu_rdata_o, m_rdata);
                check("lsu_err",   lsu_err_o,   m_err);
            end
            if (e_rv && !own_lsu) begin
                check("if_rdata", if_rdata_o, m_rdata);
                check("if_err",   if_err_o,   m_err);
            end
        end

        // Advance the model to the next cycle.
        if (reset === 1'b1) begin
            armed  = 1'b1;
            busy   = 1'b0;
            starve = 0;
        end else if (armed) begin
            if (busy && cyc == r_cyc) begin
                busy = 1'b0;
            end else if (busy && r_cyc < 0 && cyc >= g_cyc + 2) begin
                if (mem_rvalid_i === 1'b1) begin
                    r_cyc   = cyc + 1;
                    m_err   = 1'b0;
                    m_rdata = m_we ? 32'h0 : mem_rdata_i;
                end else if (cyc == g_cyc + 1 + TIMEOUT_CYCLES) begin
                    r_cyc   = cyc + 1;
                    m_err   = 1'b1;
                    m_rdata = 32'h0;
                end
            end
            if (e_lsu_gnt) begin
                busy = 1'b1; g_cyc = cyc; r_cyc = -1; own_lsu = 1'b1;
                m_we = lsu_we_i; m_be = lsu_be_i; m_addr = lsu_addr_i; m_wdata = lsu_wdata_i;
                if (if_req_i && starve < STARVE_LIMIT) starve++;
            end else if (e_if_gnt) begin
                busy = 1'b1; g_cyc = cyc; r_cyc = -1; own_lsu = 1'b0;
                m_we = 1'b0; m_be = 4'hF; m_addr = if_addr_i; m_wdata = 32'h0;
                starve = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Raise the selected requests and hold each until its grant is seen.
    task automatic serve(input bit do_if, input logic [31:0] if_addr,
                         input bit do_lsu, input bit we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input string tag);
        bit want_if  = do_if;
        bit want_lsu = do_lsu;
        if_req_i    = do_if;
        if_addr_i   = if_addr;
        lsu_req_i   = do_lsu;
        lsu_we_i    = we;
        lsu_be_i    = be;
        lsu_addr_i  = addr;
        lsu_wdata_i = wdata;
        for (int k = 0; k < 100 && (want_if || want_lsu); k++) begin
            @(negedge clock);
            if (if_gnt_o === 1'b1)  want_if  = 1'b0;
            if (lsu_gnt_o === 1'b1) want_lsu = 1'b0;
            @(posedge clock);
            #1;
            if (!want_if)  if_req_i  = 1'b0;
            if (!want_lsu) lsu_req_i = 1'b0;
        end
        check({tag, "_grant_wait"}, {30'h0, want_if, want_lsu}, 32'h0);
        if_req_i  = 1'b0;
        lsu_req_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_if_gnt"},       if_gnt_o,     32'h0);
        check({tag, "_lsu_gnt"},      lsu_gnt_o,    32'h0);
        check({tag, "_if_rvalid"},    if_rvalid_o,  32'h0);
        check({tag, "_if_rdata"},     if_rdata_o,   32'h0);
        check({tag, "_if_err"},       if_err_o,     32'h0);
        check({tag, "_lsu_rvalid"},   lsu_rvalid_o, 32'h0);
        check({tag, "_lsu_rdata"},    lsu_rdata_o,  32'h0);
        check({tag, "_lsu_err"},      lsu_err_o,    32'h0);
        check({tag, "_mem_req"},      mem_req_o,    32'h0);
        check({tag, "_mem_we"},       mem_we_o,     32'h0);
        check({tag, "_mem_be"},       mem_be_o,     32'h0);
        check({tag, "_mem_addr"},     mem_addr_o,   32'h0);
        check({tag, "_mem_wdata"},    mem_wdata_o,  32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        int start;
        int cnt_before;
        byte exp_g;

        reset       = 1'b1;
        if_req_i    = 1'b0;
        if_addr_i   = 32'h0;
        lsu_req_i   = 1'b0;
        lsu_we_i    = 1'b0;
        lsu_be_i    = 4'h0;
        lsu_addr_i  = 32'h0;
        lsu_wdata_i = 32'h0;

        // 1: reset for three cycles, then idle with no requests.
        tick(3);
        reset = 1'b0;
        tick(4);
        @(negedge clock);
        check_all_zero("t1");

        // 2: single fetch, memory answers one cycle after the request.
        tick(1);
        mem_delay = 1;
        mem_data  = 32'hDEADBEEF;
        serve(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, "t2");
        tick(6);
        check("t2_req_latency",    last_req_cyc - last_if_gnt_cyc,   32'd1);
        check("t2_req_addr",       last_req_addr,                    32'h10);
        check("t2_req_be",         last_req_be,                      32'hF);
        check("t2_req_we",         last_req_we,                      32'h0);
        check("t2_rvalid_latency", last_if_rv_cyc - last_if_gnt_cyc, 32'd3);
        check("t2_rdata",          last_if_rdata,                    32'hDEADBEEF);
        check("t2_err",            last_if_err,                      32'h0);

        // 3: fetch and store together; store wins, fetch follows.
        mem_data = 32'hCAFEF00D;
        serve(1'b1, 32'h30, 1'b1, 1'b1, 4'b0011, 32'h20, 32'h1234, "t3");
        tick(6);
        check("t3_lsu_first",  last_if_gnt_cyc - last_lsu_gnt_cyc, 32'd4);
        check("t3_st_addr",    last_st_addr,   32'h20);
        check("t3_st_be",      last_st_be,     32'h3);
        check("t3_st_wdata",   last_st_wdata,  32'h1234);
        check("t3_st_rdata",   last_lsu_rdata, 32'h0);
        check("t3_st_err",     last_lsu_err,   32'h0);
        check("t3_if_rdata",   last_if_rdata,  32'hCAFEF00D);

        // 4: both ports request continuously; fetch wins every fifth grant.
        start       = grant_log.size();
        cnt_before  = if_rv_count;
        if_addr_i   = 32'h100;
        lsu_we_i    = 1'b0;
        lsu_be_i    = 4'hF;
        lsu_addr_i  = 32'h200;
        lsu_wdata_i = 32'h0;
        if_req_i    = 1'b1;
        lsu_req_i   = 1'b1;
        for (int k = 0; k < 200 && grant_log.size() < start + 10; k++) tick(1);
        if_req_i  = 1'b0;
        lsu_req_i = 1'b0;
        tick(6);
        check("t4_grant_count", grant_log.size() - start, 32'd10);
        for (int i = 0; i < 10 && start + i < grant_log.size(); i++) begin
            exp_g = (i % 5 == 4) ? 8'h49 : 8'h4C;
            check($sformatf("t4_grant%0d", i), grant_log[start + i], exp_g);
        end
        check("t4_if_responses", if_rv_count - cnt_before, 32'd2);

        // 5: memory never answers a load; timeout error, then a stray pulse.
        mem_delay = 0;
        serve(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0, "t5");
        tick(20);
        check("t5_timeout_latency", last_lsu_rv_cyc - last_lsu_gnt_cyc, 32'd18);
        check("t5_err",             last_lsu_err,   32'h1);
        check("t5_rdata",           last_lsu_rdata, 32'h0);
        cnt_before = lsu_rv_count;
        inject_at  = cyc + 2;
        tick(5);
        check("t5_late_ignored", lsu_rv_count - cnt_before, 32'd0);

        // 6: reset during WAIT, late memory answer, then a clean fetch.
        mem_delay  = 4;
        cnt_before = if_rv_count;
        serve(1'b1, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, "t6");
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        @(negedge clock);
        check_all_zero("t6");
        tick(8);
        check("t6_no_response", if_rv_count - cnt_before, 32'd0);
        mem_delay = 1;
        mem_data  = 32'h0BADF00D;
        serve(1'b1, 32'hC0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, "t6b");
        tick(6);
        check("t6_req_addr",       last_req_addr,                    32'hC0);
        check("t6_rvalid_latency", last_if_rv_cyc - last_if_gnt_cyc, 32'd3);
        check("t6_rdata",          last_if_rdata,                    32'h0BADF00D);
        check("t6_err",            last_if_err,                      32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
